// File: rtl/run_detect_ctrl.sv
// Serial run-of-RUN detector sequencer: loads a word, shifts it out LSB-first,
// flags runs of identical bits and keeps per-job hit statistics.
module run_detect_ctrl #(
  parameter int WIDTH = 16,
  parameter int RUN   = 4,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] data,
  input  logic [CNT_W-1:0] len,
  input  logic             abort,
  output logic             busy,
  output logic             done,
  output logic             w_out,
  output logic             z,
  output logic [CNT_W-1:0] hit_count,
  output logic [CNT_W-1:0] first_hit,
  output logic             hit_seen
);

  localparam int RW = $clog2(RUN + 1);
  localparam logic [CNT_W-1:0] WMAX  = CNT_W'(WIDTH);
  localparam logic [RW-1:0]    RUN_C = RW'(RUN);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] shreg_q;
  logic [CNT_W-1:0] rem_q;
  logic [CNT_W-1:0] idx_q;
  logic [RW-1:0]    run_q;
  logic             last_q;
  logic             busy_q;
  logic             done_q;
  logic             w_out_q;
  logic             z_q;
  logic [CNT_W-1:0] hit_count_q;
  logic [CNT_W-1:0] first_hit_q;
  logic             hit_seen_q;

  logic [CNT_W-1:0] len_c;
  logic [RW-1:0]    run_d;
  logic             hit_d;
  logic [CNT_W-1:0] hit_count_d;

  // w_out_q is the bit being consumed on the current SHIFT edge
  always_comb begin
    len_c = (len > WMAX) ? WMAX : len;
    run_d = RW'(1);
    if (idx_q != '0 && w_out_q == last_q) begin
      run_d = (run_q == RUN_C) ? RUN_C : run_q + RW'(1);
    end
    hit_d = (run_d == RUN_C);
    hit_count_d = hit_count_q;
    if (hit_d && hit_count_q != {CNT_W{1'b1}}) begin
      hit_count_d = hit_count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      shreg_q     <= '0;
      rem_q       <= '0;
      idx_q       <= '0;
      run_q       <= '0;
      last_q      <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      w_out_q     <= 1'b0;
      z_q         <= 1'b0;
      hit_count_q <= '0;
      first_hit_q <= '0;
      hit_seen_q  <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            shreg_q     <= data >> 1;
            w_out_q     <= (len_c != '0) && data[0];
            rem_q       <= len_c;
            idx_q       <= '0;
            run_q       <= '0;
            last_q      <= 1'b0;
            z_q         <= 1'b0;
            hit_count_q <= '0;
            first_hit_q <= '0;
            hit_seen_q  <= 1'b0;
            if (len_c != '0) begin
              state_q <= SHIFT;
              busy_q  <= 1'b1;
            end else begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end
          end
        end
        SHIFT: begin
          if (abort) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            w_out_q <= 1'b0;
            z_q     <= 1'b0;
          end else begin
            run_q       <= run_d;
            last_q      <= w_out_q;
            z_q         <= hit_d;
            hit_count_q <= hit_count_d;
            if (hit_d && !hit_seen_q) begin
              first_hit_q <= idx_q;
              hit_seen_q  <= 1'b1;
            end
            idx_q   <= idx_q + CNT_W'(1);
            rem_q   <= rem_q - CNT_W'(1);
            shreg_q <= shreg_q >> 1;
            if (rem_q == CNT_W'(1)) begin
              state_q <= DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              w_out_q <= 1'b0;
            end else begin
              w_out_q <= shreg_q[0];
            end
          end
        end
        DONE: begin
          state_q <= IDLE;
          done_q  <= 1'b0;
          z_q     <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign w_out     = w_out_q;
  assign z         = z_q;
  assign hit_count = hit_count_q;
  assign first_hit = first_hit_q;
  assign hit_seen  = hit_seen_q;

endmodule

// File: tb/tb_run_detect_ctrl.sv
// Bench for run_detect_ctrl: job-timeline reference model checked every
// cycle, directed scenarios with literal expectations, then random jobs.
module tb_run_detect_ctrl;

  localparam int WIDTH = 16;
  localparam int RUN   = 4;
  localparam int CNT_W = $clog2(WIDTH + 1);

  logic             clock = 1'b0;
  logic             reset = 1'b1;
  logic             start = 1'b0;
  logic [WIDTH-1:0] data  = '0;
  logic [CNT_W-1:0] len   = '0;
  logic             abort = 1'b0;
  logic             busy, done, w_out, z, hit_seen;
  logic [CNT_W-1:0] hit_count, first_hit;

  run_detect_ctrl #(.WIDTH(WIDTH), .RUN(RUN)) dut (
    .clock(clock), .reset(reset), .start(start), .data(data),
    .len(len), .abort(abort), .busy(busy), .done(done),
    .w_out(w_out), .z(z), .hit_count(hit_count),
    .first_hit(first_hit), .hit_seen(hit_seen)
  );

  always #5 clock = ~clock;

  int vecs = 0;
  int errs = 0;
  int cyc  = 0;

  // reference model: one job described by its accept cycle and its bits
  bit             job_v = 0;
  int             t0, jl, ja;
  bit             ab;
  bit [WIDTH-1:0] bits;
  bit             za [WIDTH];

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", nm, cyc, act, exp);
    end
  endtask

  function automatic void results(int n, output int hc, output int fh,
                                  output bit sn);
    hc = 0; fh = 0; sn = 0;
    for (int k = 0; k < n; k++) begin
      if (za[k]) begin
        if (!sn) fh = k;
        sn = 1;
        if (hc < (1 << CNT_W) - 1) hc++;
      end
    end
  endfunction

  function automatic int jidx();
    return cyc - t0 - 1;
  endfunction

  function automatic bit m_idle();
    if (!job_v) return 1;
    return ab ? (jidx() > ja) : (jidx() > jl);
  endfunction

  function automatic bit m_busy();
    if (!job_v) return 0;
    return jidx() < jl && (!ab || jidx() <= ja);
  endfunction

  task automatic compare();
    int j, lim, n, hc, fh;
    bit eb, ed, ew, ez, sn;
    eb = 0; ed = 0; ew = 0; ez = 0; hc = 0; fh = 0; sn = 0;
    if (job_v) begin
      j   = jidx();
      lim = ab ? ja : jl;
      n   = (j < lim) ? j : lim;
      eb  = m_busy();
      ed  = !ab && j == jl;
      ew  = eb ? bits[j] : 1'b0;
      ez  = (eb || ed) && n > 0 ? za[n-1] : 1'b0;
      results(n, hc, fh, sn);
    end
    chk("busy", busy, eb);
    chk("done", done, ed);
    chk("w_out", w_out, ew);
    chk("z", z, ez);
    chk("hit_count", hit_count, hc);
    chk("first_hit", first_hit, fh);
    chk("hit_seen", hit_seen, sn);
  endtask

  task automatic tick(bit s, logic [WIDTH-1:0] d, int l, bit a);
    @(negedge clock);
    cyc++;
    compare();
    start = s; data = d; len = CNT_W'(l); abort = a;
    if (s && m_idle()) begin
      job_v = 1; t0 = cyc; ab = 0;
      jl    = (l > WIDTH) ? WIDTH : l;
      bits  = d;
      for (int k = 0; k < WIDTH; k++) begin
        za[k] = 0;
        if (k >= RUN - 1 && k < jl) begin
          za[k] = 1;
          for (int m = k - RUN + 1; m < k; m++)
            if (bits[m] != bits[k]) za[k] = 0;
        end
      end
    end else if (a && m_busy()) begin
      ab = 1; ja = jidx();
    end
  endtask

  task automatic run_job(logic [WIDTH-1:0] d, int l, int lat,
                         int hc, int fh, bit sn);
    int ts, dc;
    tick(1, d, l, 0);
    ts = cyc;
    dc = -1;
    for (int i = 0; i < 40 && dc < 0; i++) begin
      tick(0, '0, 0, 0);
      if (done) dc = cyc;
    end
    chk("done_latency", dc - ts, lat);
    chk("lit_hit_count", hit_count, hc);
    chk("lit_first_hit", first_hit, fh);
    chk("lit_hit_seen", hit_seen, sn);
  endtask

  task automatic hard_reset();
    #2 reset = 1'b1;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_z", z, 0);
    chk("rst_w_out", w_out, 0);
    chk("rst_hit_count", hit_count, 0);
    chk("rst_first_hit", first_hit, 0);
    chk("rst_hit_seen", hit_seen, 0);
    #1 reset = 1'b0;
    job_v = 0;
  endtask

  initial begin
    #1;
    chk("por_busy", busy, 0);
    chk("por_hit_count", hit_count, 0);
    chk("por_w_out", w_out, 0);
    #3 reset = 1'b0;

    run_job(16'h000F, 8, 9, 2, 3, 1);
    run_job(16'h003F, 6, 7, 3, 3, 1);
    run_job(16'h5555, 16, 17, 0, 0, 0);
    run_job(16'h1234, 0, 1, 0, 0, 0);
    run_job(16'h0000, 20, 17, 13, 3, 1);

    // abort in the third SHIFT cycle, with a stray start while busy
    tick(1, 16'hFFFF, 16, 0);
    tick(0, '0, 0, 0);
    tick(1, 16'h0F0F, 8, 0);
    tick(0, '0, 0, 1);
    tick(0, '0, 0, 0);
    chk("abort_busy", busy, 0);
    chk("abort_hit_count", hit_count, 0);
    for (int i = 0; i < 20; i++) tick(0, '0, 0, 0);
    chk("abort_no_done", done, 0);

    // reset in the middle of a job that already has hits
    tick(1, 16'h0000, 16, 0);
    for (int i = 0; i < 7; i++) tick(0, '0, 0, 0);
    chk("pre_rst_hits", hit_count, 3);
    hard_reset();
    run_job(16'h000F, 8, 9, 2, 3, 1);

    for (int i = 0; i < 1500; i++) begin
      bit s, a;
      logic [WIDTH-1:0] d;
      s = ($urandom_range(0, 3) == 0);
      a = ($urandom_range(0, 24) == 0);
      d = WIDTH'($urandom);
      if ($urandom_range(0, 2) == 0) d = d & WIDTH'($urandom);
      if ($urandom_range(0, 3) == 0) d = ~(d & WIDTH'($urandom));
      tick(s, d, $urandom_range(0, 20), a);
      if ($urandom_range(0, 299) == 0) hard_reset();
    end
    tick(0, '0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/run_detect_ctrl.md
Name: run_detect_ctrl

Overview:
- Sequencer for the run-of-N sequence detector (the 0000/1111 recognizer).
- Accepts a parallel word and a bit count, then shifts the word out LSB-first, one bit per clock.
- Tracks runs of identical bits (overlap allowed), counts detections and records the first detection index.
- Start/busy/done handshake to the surrounding control logic; the serial bit and detector output are exported for LED display.

Parameters:
- WIDTH, 16, maximum bits per job (width of data).
- RUN, 4, consecutive identical bits required for a detection (RUN >= 2).
- CNT_W, $clog2(WIDTH+1), width of len, hit_count and first_hit.

Ports:
- clock  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  job request; sampled only in IDLE.
- data  input  WIDTH  word to scan, bit 0 first.
- len  input  CNT_W  number of bits to scan; values above WIDTH are clamped to WIDTH.
- abort  input  1  cancel the current job.
- busy  output  1  high in SHIFT.
- done  output  1  one-cycle pulse at job completion.
- w_out  output  1  serial bit currently being fed to the detector.
- z  output  1  detection flag: the last RUN scanned bits are all 0 or all 1.
- hit_count  output  CNT_W  number of detection cycles in the current or last job.
- first_hit  output  CNT_W  0-based bit index that completed the first run.
- hit_seen  output  1  high if at least one detection occurred in the job.

Behaviour:
- Reset (asynchronous, immediate): state=IDLE; shift register, run counter, bit index and all outputs cleared to 0. A reset mid-job abandons the job and produces no done pulse.
- States and transitions:
  - IDLE: start=1 → capture data, remaining=min(len,WIDTH). Clear hit_count, first_hit, hit_seen, run history and index. Next state is SHIFT if remaining>0, else DONE.
  - SHIFT: each cycle register w_out<=shreg[0], shift shreg right, increment index, decrement remaining. Go to DONE when the last bit is consumed, or to IDLE on abort.
  - DONE: done=1 for exactly one cycle, then IDLE.
- Handshake and timing:
  - start is ignored outside IDLE; busy=0 in IDLE and DONE.
  - For a start accepted at cycle t with length L>0: w_out=data[k] is valid in cycles t+1+k; z for bit k appears one cycle later; done pulses at t+L+1.
  - For L=0: done pulses at t+1 and all results are 0.
- Run detector, updated per consumed bit b at index i:
  - run = (i>0 && b==last) ? min(run+1,RUN) : 1; last=b.
  - z registered = (run==RUN). Runs longer than RUN keep z high on every extra bit, so overlap is counted.
  - Run history does not carry across jobs.
- Detection bookkeeping:
  - hit_count increments on each detection and saturates at 2^CNT_W-1.
  - On the first detection: first_hit=i, hit_seen=1.
  - With no detection, first_hit=0 and hit_seen=0.
- Result hold rules:
  - z holds through DONE and clears on entry to IDLE.
  - hit_count, first_hit and hit_seen hold until the next accepted start.
- abort:
  - abort in SHIFT → IDLE next cycle, busy falls, no done pulse, partial results hold.
  - abort in IDLE or DONE has no effect.
  - abort and the last-bit cycle together → abort wins.
- Simultaneous start and abort in IDLE: start wins.

Test Plan:
- data=16'h000F, len=8, start pulse → bits 1,1,1,1,0,0,0,0; z high for bit indices 3 and 7; hit_count=2, first_hit=3, hit_seen=1; done at t+9.
- data=16'h003F, len=6 → overlap detections at indices 3, 4, 5; hit_count=3, first_hit=3.
- data=16'h5555, len=16 → z never high; hit_count=0, hit_seen=0, first_hit=0; done at t+17.
- len=0 → done at t+1 with zero results. Then data=16'h0000, len=20 (clamped to 16) → hit_count=13, first_hit=3.
- Start a 16-bit job; assert abort in the 3rd SHIFT cycle and pulse start during busy → busy low next cycle, no done pulse, second start ignored, partial counts held.
- Assert reset mid-SHIFT → busy, done, z, w_out and counters are 0 immediately. After reset release a new job runs normally with no carried run history.
